// File: rtl/dsram_ctrl.sv
// Data-side SRAM controller: one cache load/store per transaction against a
// synchronous SRAM with fixed wait states. Optional alignment check: DSRAM_ALIGN_CHECK_EN.
module dsram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [2:0]         mem_type,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        dout,
  output logic               ok,
  output logic [31:0]        din,
`ifdef DSRAM_ALIGN_CHECK_EN
  output logic               misalign,
`endif
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_l;
  logic [2:0]       type_l;
  logic [1:0]       lane_l;

  // Address bits above the SRAM word range never reach the pins.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:SRAM_AW+2];

  function automatic logic [3:0] be_of(input logic [2:0] mt, input logic [1:0] a);
    case (mt)
      3'd0, 3'd1: be_of = 4'(4'b0001 << a);
      3'd2, 3'd3: be_of = a[1] ? 4'b1100 : 4'b0011;
      default:    be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] mt, input logic [31:0] d);
    case (mt)
      3'd0, 3'd1: wdata_of = {4{d[7:0]}};
      3'd2, 3'd3: wdata_of = {2{d[15:0]}};
      default:    wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] mt, input logic [1:0] a,
                                          input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (mt)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd1:    extract = {24'b0, b};
      3'd2:    extract = {{16{h[15]}}, h};
      3'd3:    extract = {16'b0, h};
      default: extract = r;
    endcase
  endfunction

`ifdef DSRAM_ALIGN_CHECK_EN
  logic misaligned_c;
  always_comb begin
    misaligned_c = 1'b0;
    case (mem_type)
      3'd0, 3'd1: misaligned_c = 1'b0;
      3'd2, 3'd3: misaligned_c = addr[0];
      default:    misaligned_c = (addr[1:0] != 2'b00);
    endcase
  end
`endif

  // Controller FSM; every output is a register so reset drops the strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_l       <= 1'b0;
      type_l     <= 3'd0;
      lane_l     <= 2'd0;
      ok         <= 1'b0;
      din        <= 32'd0;
`ifdef DSRAM_ALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_addr  <= '0;
      sram_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ok <= 1'b0;
          if (req) begin
            we_l   <= we;
            type_l <= mem_type;
            lane_l <= addr[1:0];
`ifdef DSRAM_ALIGN_CHECK_EN
            if (misaligned_c) begin
              state    <= DONE;
              ok       <= 1'b1;
              misalign <= 1'b1;
            end else begin
`else
            begin
`endif
              state      <= ACCESS;
              cnt        <= CNT_W'(WAIT_CYCLES - 1);
              sram_ce_n  <= 1'b0;
              sram_we_n  <= ~we;
              sram_be_n  <= ~be_of(mem_type, addr[1:0]);
              sram_addr  <= addr[SRAM_AW+1:2];
              sram_wdata <= wdata_of(mem_type, dout);
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= DONE;
            ok        <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            if (!we_l) din <= extract(type_l, lane_l, sram_rdata);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Any req seen here is dropped; the cache re-presents it in IDLE.
          state <= IDLE;
          ok    <= 1'b0;
`ifdef DSRAM_ALIGN_CHECK_EN
          misalign <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_ctrl.sv
// Directed bench for dsram_ctrl (default WAIT_CYCLES=2); covers the
// DSRAM_ALIGN_CHECK_EN build when that macro is defined.
module tb_dsram_ctrl;

  localparam int unsigned W       = 2;
  localparam int unsigned SRAM_AW = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               req;
  logic               we;
  logic [2:0]         mem_type;
  logic [31:0]        addr;
  logic [31:0]        dout;
  logic               ok;
  logic [31:0]        din;
`ifdef DSRAM_ALIGN_CHECK_EN
  logic               misalign;
`endif
  logic               sram_ce_n;
  logic               sram_we_n;
  logic [3:0]         sram_be_n;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]         be_seen;
  logic [SRAM_AW-1:0] addr_seen;
  logic [31:0]        wd_seen;

  dsram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(32), .SRAM_AW(SRAM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .mem_type   (mem_type),
    .addr       (addr),
    .dout       (dout),
    .ok         (ok),
    .din        (din),
`ifdef DSRAM_ALIGN_CHECK_EN
    .misalign   (misalign),
`endif
    .sram_ce_n  (sram_ce_n),
    .sram_we_n  (sram_we_n),
    .sram_be_n  (sram_be_n),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle, then scramble the payload and watch until ok (bounded).
  task automatic txn(input logic w, input logic [2:0] mt, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output int ce_cnt,
                     output int we_cnt);
    we = w; mem_type = mt; addr = a; dout = d; req = 1'b1;
    tick();
    req = 1'b0; we = ~w; mem_type = 3'd1; addr = 32'hFFFF_FFFF; dout = 32'h0;
    lat = 0; ce_cnt = 0; we_cnt = 0;
    while (ok !== 1'b1 && lat < 20) begin
      if (sram_ce_n === 1'b0) begin
        ce_cnt++;
        be_seen = sram_be_n; addr_seen = sram_addr; wd_seen = sram_wdata;
      end
      if (sram_we_n === 1'b0) we_cnt++;
      tick();
      lat++;
    end
  endtask

  int lat, ce_cnt, we_cnt, gap;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; mem_type = 3'd0; addr = 32'd0;
    dout = 32'd0; sram_rdata = 32'd0;
    tick(); tick();
    check("rst_ok",    32'(ok), 32'd0);
    check("rst_din",   din, 32'd0);
    check("rst_ce_n",  32'(sram_ce_n), 32'd1);
    check("rst_we_n",  32'(sram_we_n), 32'd1);
    check("rst_be_n",  32'(sram_be_n), 32'hF);
    check("rst_addr",  32'(sram_addr), 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
`ifdef DSRAM_ALIGN_CHECK_EN
    check("rst_misalign", 32'(misalign), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Reset in the middle of an access
    we = 1'b0; mem_type = 3'd4; addr = 32'h10; req = 1'b1;
    tick();
    req = 1'b0;
    check("abort_ce_active", 32'(sram_ce_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_ce_n", 32'(sram_ce_n), 32'd1);
    check("abort_be_n", 32'(sram_be_n), 32'hF);
    check("abort_ok",   32'(ok), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("abort_no_ok", 32'(ok), 32'd0);

    // Word load after abort
    sram_rdata = 32'h1122_3344;
    txn(1'b0, 3'd4, 32'h10, 32'h0, lat, ce_cnt, we_cnt);
    check("wload_lat",  32'(lat), 32'(W));
    check("wload_ce",   32'(ce_cnt), 32'(W));
    check("wload_addr", 32'(addr_seen), 32'h4);
    check("wload_din",  din, 32'h1122_3344);
    tick();
    check("wload_ok_pulse", 32'(ok), 32'd0);

    // Word store
    txn(1'b1, 3'd4, 32'h104, 32'hDEAD_BEEF, lat, ce_cnt, we_cnt);
    check("wst_lat",   32'(lat), 32'(W));
    check("wst_we",    32'(we_cnt), 32'(W));
    check("wst_addr",  32'(addr_seen), 32'h41);
    check("wst_be_n",  32'(be_seen), 32'h0);
    check("wst_wdata", wd_seen, 32'hDEAD_BEEF);
    check("wst_din_hold", din, 32'h1122_3344);
    check("wst_we_n_idle", 32'(sram_we_n), 32'd1);
    tick();

    // Byte / ubyte load, lane 2
    sram_rdata = 32'h8899_AABB;
    txn(1'b0, 3'd0, 32'h202, 32'h0, lat, ce_cnt, we_cnt);
    check("bload_lat",  32'(lat), 32'(W));
    check("bload_be_n", 32'(be_seen), 32'hB);
    check("bload_we",   32'(we_cnt), 32'd0);
    check("bload_din",  din, 32'hFFFF_FF99);
    tick();
    txn(1'b0, 3'd1, 32'h202, 32'h0, lat, ce_cnt, we_cnt);
    check("ubload_din", din, 32'h0000_0099);
    tick();

    // Half store upper lane, half/uhalf loads
    txn(1'b1, 3'd2, 32'h302, 32'h0000_1234, lat, ce_cnt, we_cnt);
    check("hst_be_n",  32'(be_seen), 32'h3);
    check("hst_wdata", wd_seen, 32'h1234_1234);
    check("hst_addr",  32'(addr_seen), 32'hC0);
    tick();
    sram_rdata = 32'h8000_1111;
    txn(1'b0, 3'd2, 32'h302, 32'h0, lat, ce_cnt, we_cnt);
    check("hload_din", din, 32'hFFFF_8000);
    tick();
    sram_rdata = 32'h8000_F00D;
    txn(1'b0, 3'd3, 32'h300, 32'h0, lat, ce_cnt, we_cnt);
    check("uhload_be_n", 32'(be_seen), 32'hC);
    check("uhload_din",  din, 32'h0000_F00D);
    tick();

    // Back-to-back with req held high; payload changes during the first access
    sram_rdata = 32'h8899_AABB;
    we = 1'b0; mem_type = 3'd4; addr = 32'h10; req = 1'b1;
    tick();
    mem_type = 3'd0; addr = 32'h21;
    check("b2b_addr1", 32'(sram_addr), 32'h4);
    lat = 0;
    while (ok !== 1'b1 && lat < 20) begin tick(); lat++; end
    check("b2b_lat1", 32'(lat), 32'(W));
    check("b2b_din1", din, 32'h8899_AABB);
    tick();
    gap = 1;
    while (ok !== 1'b1 && gap < 20) begin tick(); gap++; end
    req = 1'b0;
    check("b2b_gap",  32'(gap), 32'(W + 2));
    check("b2b_din2", din, 32'hFFFF_FFAA);
    tick();
    check("b2b_ok_pulse", 32'(ok), 32'd0);
    tick(); tick(); tick();
    check("b2b_idle_ce", 32'(sram_ce_n), 32'd1);

`ifdef DSRAM_ALIGN_CHECK_EN
    // Misaligned word load never touches the SRAM
    we = 1'b0; mem_type = 3'd4; addr = 32'h106; req = 1'b1;
    tick();
    req = 1'b0;
    check("mis_ok",       32'(ok), 32'd1);
    check("mis_flag",     32'(misalign), 32'd1);
    check("mis_ce_n",     32'(sram_ce_n), 32'd1);
    check("mis_din_hold", din, 32'hFFFF_FFAA);
    tick();
    check("mis_ok_clr",   32'(ok), 32'd0);
    check("mis_flag_clr", 32'(misalign), 32'd0);
    check("mis_ce_n2",    32'(sram_ce_n), 32'd1);
    tick();
    sram_rdata = 32'h0BAD_F00D;
    txn(1'b0, 3'd4, 32'h108, 32'h0, lat, ce_cnt, we_cnt);
    check("aligned_flag", 32'(misalign), 32'd0);
    check("aligned_din",  din, 32'h0BAD_F00D);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
